// File: rtl/ro_odometer_pkg.sv
// Shared types and constants for the RO odometer scan controller.
// The FSM states are one-hot; the mode codes are the ones the sn_cdir decoder expects.
package ro_odometer_pkg;

  typedef enum logic [6:0] {
    ST_IDLE    = 7'b0000001,
    ST_STRESS  = 7'b0000010,
    ST_SETTLE  = 7'b0000100,
    ST_MEASURE = 7'b0001000,
    ST_EMIT    = 7'b0010000,
    ST_NEXT    = 7'b0100000,
    ST_FIN     = 7'b1000000
  } state_e;

  localparam logic [1:0] MODE_RST    = 2'b00;
  localparam logic [1:0] MODE_STRESS = 2'b01;
  localparam logic [1:0] MODE_AUTH   = 2'b10;

endpackage

// File: rtl/ro_mask_next_chan.sv
// Combinational priority finder: returns the lowest set mask bit strictly above
// idx_i, or the lowest set bit overall when from_start_i is high.
module ro_mask_next_chan
  import ro_odometer_pkg::*;
#(
  parameter int NO_CDIR = 8,
  parameter int SEL_W   = $clog2(NO_CDIR)
) (
  input  logic [NO_CDIR-1:0] mask_i,
  input  logic [SEL_W-1:0]   idx_i,
  input  logic               from_start_i,
  output logic [SEL_W-1:0]   chan_o,
  output logic               found_o
);

  // Descending walk so the lowest qualifying bit is the last one to win.
  always_comb begin
    chan_o  = '0;
    found_o = 1'b0;
    for (int i = NO_CDIR - 1; i >= 0; i--) begin
      if (mask_i[i] && (from_start_i || (i > int'(idx_i)))) begin
        chan_o  = SEL_W'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ro_odometer_scan_ctrl.sv
// Lifecycle-odometer controller: scans every enabled CDIR channel of an external
// RO array, reports r/s counts, signed difference and aged flag over valid/ready.
module ro_odometer_scan_ctrl
  import ro_odometer_pkg::*;
#(
  parameter int NO_CDIR       = 8,
  parameter int SEL_W         = $clog2(NO_CDIR),
  parameter int CNT_W         = 32,
  parameter int SETTLE_CYCLES = 4,
  parameter int TIMEOUT       = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     go,
  input  logic                     en_out,
  input  logic [NO_CDIR-1:0]       chan_mask,
  input  logic [CNT_W-1:0]         thr,
  output logic [1:0]               mode,
  output logic [SEL_W-1:0]         r_mux_sel,
  output logic [SEL_W-1:0]         s_mux_sel,
  input  logic [CNT_W-1:0]         dec_r_freq,
  input  logic [CNT_W-1:0]         dec_s_freq,
  input  logic                     dec_valid,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [SEL_W-1:0]         res_chan,
  output logic [CNT_W-1:0]         res_r_freq,
  output logic [CNT_W-1:0]         res_s_freq,
  output logic signed [CNT_W:0]    res_diff,
  output logic                     res_aged,
  output logic                     res_timeout,
  output logic                     busy,
  output logic                     done,
  output logic [NO_CDIR-1:0]       aged_map
);

  localparam int ST_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  // Zero-extend both counts so the difference never wraps.
  function automatic logic signed [CNT_W:0] sub_ext(input logic [CNT_W-1:0] a,
                                                    input logic [CNT_W-1:0] b);
    return $signed({1'b0, a}) - $signed({1'b0, b});
  endfunction

  state_e                state_q;
  logic [1:0]            mode_q;
  logic [SEL_W-1:0]      sel_q;
  logic [NO_CDIR-1:0]    mask_q;
  logic [CNT_W-1:0]      thr_q;
  logic [ST_W-1:0]       settle_q;
  logic [TO_W-1:0]       tmo_q;
  logic                  res_valid_q;
  logic [SEL_W-1:0]      res_chan_q;
  logic [CNT_W-1:0]      res_r_q;
  logic [CNT_W-1:0]      res_s_q;
  logic signed [CNT_W:0] res_diff_q;
  logic                  res_aged_q;
  logic                  res_timeout_q;
  logic                  busy_q;
  logic                  done_q;
  logic [NO_CDIR-1:0]    aged_map_q;

  logic signed [CNT_W:0] diff_d;
  logic                  aged_d;
  logic                  find_start;
  logic [NO_CDIR-1:0]    find_mask;
  logic [SEL_W-1:0]      next_chan;
  logic                  next_found;

  assign diff_d = sub_ext(dec_r_freq, dec_s_freq);
  assign aged_d = diff_d > $signed({1'b0, thr_q});

  // Scan start searches the live mask from bit 0; NEXT searches the latched mask above sel_q.
  assign find_start = (state_q != ST_NEXT);
  assign find_mask  = find_start ? chan_mask : mask_q;

  ro_mask_next_chan #(
    .NO_CDIR (NO_CDIR),
    .SEL_W   (SEL_W)
  ) u_next_chan (
    .mask_i       (find_mask),
    .idx_i        (sel_q),
    .from_start_i (find_start),
    .chan_o       (next_chan),
    .found_o      (next_found)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      mode_q        <= MODE_RST;
      sel_q         <= '0;
      mask_q        <= '0;
      thr_q         <= '0;
      settle_q      <= '0;
      tmo_q         <= '0;
      res_valid_q   <= 1'b0;
      res_chan_q    <= '0;
      res_r_q       <= '0;
      res_s_q       <= '0;
      res_diff_q    <= '0;
      res_aged_q    <= 1'b0;
      res_timeout_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      aged_map_q    <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE, ST_STRESS: begin
          if (en_out) begin
            mask_q   <= chan_mask;
            thr_q    <= thr;
            busy_q   <= 1'b1;
            mode_q   <= MODE_RST;
            settle_q <= '0;
            if (next_found) begin
              sel_q   <= next_chan;
              state_q <= ST_SETTLE;
            end else begin
              state_q <= ST_FIN;
            end
          end else if (go) begin
            state_q <= ST_STRESS;
            mode_q  <= MODE_STRESS;
          end else begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_RST;
          end
        end
        ST_SETTLE: begin
          if (settle_q == ST_W'(SETTLE_CYCLES - 1)) begin
            state_q <= ST_MEASURE;
            mode_q  <= MODE_AUTH;
            tmo_q   <= '0;
          end else begin
            settle_q <= settle_q + 1'b1;
          end
        end
        ST_MEASURE: begin
          if (dec_valid) begin
            res_r_q       <= dec_r_freq;
            res_s_q       <= dec_s_freq;
            res_diff_q    <= diff_d;
            res_aged_q    <= aged_d;
            res_timeout_q <= 1'b0;
            res_chan_q    <= sel_q;
            res_valid_q   <= 1'b1;
            state_q       <= ST_EMIT;
          end else if (tmo_q == TO_W'(TIMEOUT - 1)) begin
            res_r_q       <= '0;
            res_s_q       <= '0;
            res_diff_q    <= '0;
            res_aged_q    <= 1'b0;
            res_timeout_q <= 1'b1;
            res_chan_q    <= sel_q;
            res_valid_q   <= 1'b1;
            state_q       <= ST_EMIT;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        ST_EMIT: begin
          if (res_ready) begin
            res_valid_q       <= 1'b0;
            aged_map_q[sel_q] <= aged_map_q[sel_q] | res_aged_q;
            state_q           <= ST_NEXT;
            mode_q            <= MODE_RST;
          end
        end
        ST_NEXT: begin
          mode_q <= MODE_RST;
          if (next_found) begin
            sel_q    <= next_chan;
            settle_q <= '0;
            state_q  <= ST_SETTLE;
          end else begin
            state_q <= ST_FIN;
          end
        end
        ST_FIN: begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
          if (go) begin
            state_q <= ST_STRESS;
            mode_q  <= MODE_STRESS;
          end else begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_RST;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          mode_q  <= MODE_RST;
        end
      endcase
    end
  end

  assign mode        = mode_q;
  assign r_mux_sel   = sel_q;
  assign s_mux_sel   = sel_q;
  assign res_valid   = res_valid_q;
  assign res_chan    = res_chan_q;
  assign res_r_freq  = res_r_q;
  assign res_s_freq  = res_s_q;
  assign res_diff    = res_diff_q;
  assign res_aged    = res_aged_q;
  assign res_timeout = res_timeout_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign aged_map    = aged_map_q;

endmodule

// File: tb/tb_ro_odometer_scan_ctrl.sv
// Bench for ro_odometer_scan_ctrl: a decoder responder plus a per-scan reference
// model that lists the expected results straight from mask, counts and threshold.
module tb_ro_odometer_scan_ctrl;

  localparam int NO_CDIR = 4;
  localparam int SEL_W   = 2;
  localparam int CNT_W   = 32;
  localparam int SETTLE  = 4;
  localparam int TMO     = 16;

  logic               clk = 1'b0;
  logic               rst, go, en_out, dec_valid, res_ready;
  logic [NO_CDIR-1:0] chan_mask, aged_map;
  logic [CNT_W-1:0]   thr, dec_r_freq, dec_s_freq, res_r_freq, res_s_freq;
  logic [1:0]         mode;
  logic [SEL_W-1:0]   r_mux_sel, s_mux_sel, res_chan;
  logic signed [CNT_W:0] res_diff;
  logic               res_valid, res_aged, res_timeout, busy, done;

  int checks = 0;
  int errors = 0;
  logic [31:0] tab_r [4];
  logic [31:0] tab_s [4];
  int   dec_lat  = 0;
  bit   dec_dead = 1'b0;
  logic [3:0] exp_map = 4'b0;

  ro_odometer_scan_ctrl #(
    .NO_CDIR(NO_CDIR), .SEL_W(SEL_W), .CNT_W(CNT_W),
    .SETTLE_CYCLES(SETTLE), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .go(go), .en_out(en_out), .chan_mask(chan_mask), .thr(thr),
    .mode(mode), .r_mux_sel(r_mux_sel), .s_mux_sel(s_mux_sel),
    .dec_r_freq(dec_r_freq), .dec_s_freq(dec_s_freq), .dec_valid(dec_valid),
    .res_valid(res_valid), .res_ready(res_ready), .res_chan(res_chan),
    .res_r_freq(res_r_freq), .res_s_freq(res_s_freq), .res_diff(res_diff),
    .res_aged(res_aged), .res_timeout(res_timeout), .busy(busy), .done(done),
    .aged_map(aged_map)
  );

  always #5 clk = ~clk;

  // Decoder stand-in: valid appears dec_lat cycles after mode turns to measure.
  initial begin
    int meas_n;
    meas_n = 0;
    dec_valid = 1'b0; dec_r_freq = '0; dec_s_freq = '0;
    forever begin
      @(posedge clk); #1;
      if (mode === 2'b10 && !dec_dead) begin
        meas_n++;
        if (meas_n > dec_lat) begin
          dec_valid  = 1'b1;
          dec_r_freq = tab_r[r_mux_sel];
          dec_s_freq = tab_s[r_mux_sel];
        end
      end else begin
        meas_n = 0;
        dec_valid  = 1'b0;
        dec_r_freq = $urandom;
        dec_s_freq = $urandom;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ctrl"}, 64'({mode, r_mux_sel, s_mux_sel, res_valid, res_chan, res_aged,
                               res_timeout, busy, done, aged_map}), 64'd0);
    check({tag, "_data"}, 64'({res_r_freq, res_s_freq} | {31'b0, res_diff}), 64'd0);
  endtask

  // Runs one scan with a non-empty mask and checks every result against the model.
  task automatic run_scan(input logic [3:0] m, input logic [31:0] t,
                          input int stall_chan, input int stall_len);
    int n;
    bit first, stable;
    longint d;
    logic [31:0] er, es;
    logic [32:0] ed;
    logic ea, et;
    en_out = 1'b1; chan_mask = m; thr = t;
    @(negedge clk);
    en_out = 1'b0; chan_mask = 4'($urandom); thr = $urandom;
    first = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (!m[c]) continue;
      n = 0;
      while (mode !== 2'b10 && n < 200) begin @(negedge clk); n++; end
      if (first) check("settle_len", 64'(n), 64'(SETTLE));
      else       check("gap_min", 64'(n >= SETTLE), 64'd1);
      check("sel", 64'({r_mux_sel, s_mux_sel, busy}), 64'({c[1:0], c[1:0], 1'b1}));
      first = 1'b0;
      n = 0;
      while (res_valid !== 1'b1 && n < TMO + 50) begin @(negedge clk); n++; end
      check("meas_len", 64'(n), dec_dead ? 64'(TMO) : 64'(dec_lat + 1));
      if (dec_dead) begin
        er = 0; es = 0; ed = 0; ea = 1'b0; et = 1'b1;
      end else begin
        er = tab_r[c]; es = tab_s[c];
        d  = longint'(er) - longint'(es);
        ed = d[32:0];
        ea = d > longint'(t);
        et = 1'b0;
      end
      check("res_chan_flags", 64'({res_chan, res_aged, res_timeout}), 64'({c[1:0], ea, et}));
      check("res_r", 64'(res_r_freq), 64'(er));
      check("res_s", 64'(res_s_freq), 64'(es));
      check("res_diff", {31'b0, res_diff}, {31'b0, ed});
      exp_map[c] = exp_map[c] | ea;
      if (c == stall_chan) begin
        stable = 1'b1;
        repeat (stall_len) begin
          @(negedge clk);
          if (res_valid !== 1'b1 || mode !== 2'b10 || res_r_freq !== er || res_s_freq !== es ||
              res_diff !== $signed(ed) || res_chan !== c[1:0] || res_aged !== ea)
            stable = 1'b0;
        end
        check("emit_hold", 64'(stable), 64'd1);
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      check("valid_drop", 64'(res_valid), 64'd0);
    end
    n = 0;
    while (done !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    check("done_lat", 64'(n), 64'd2);
    check("fin_state", 64'({busy, aged_map}), 64'({1'b0, exp_map}));
    @(negedge clk);
    check("done_pulse", 64'(done), 64'd0);
  endtask

  initial begin
    int n;
    bit seen;
    rst = 1'b1; go = 1'b0; en_out = 1'b0; chan_mask = '0; thr = '0; res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin tab_r[i] = 0; tab_s[i] = 0; end
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;

    // stress mode follows go while idle
    go = 1'b1; @(negedge clk);
    check("stress_mode", 64'(mode), 64'd1);
    go = 1'b0; @(negedge clk);
    check("idle_mode", 64'(mode), 64'd0);

    // full mask, fixed counts
    tab_r = '{1000, 1000, 1000, 1000};
    tab_s = '{995, 980, 1000, 1011};
    dec_lat = 0;
    run_scan(4'b1111, 32'd10, -1, 0);

    // sparse mask with long backpressure on channel 2
    dec_lat = 3;
    run_scan(4'b0101, 32'd10, 2, 50);

    // dead decoder: every channel times out
    dec_dead = 1'b1;
    run_scan(4'b1111, 32'd3, 1, 2);
    dec_dead = 1'b0;

    // go and en_out together: scan wins, stress resumes after
    go = 1'b1; dec_lat = 1;
    run_scan(4'b1001, 32'd15, -1, 0);
    check("post_scan_stress", 64'(mode), 64'd1);
    go = 1'b0; @(negedge clk);
    check("post_scan_idle", 64'(mode), 64'd0);

    // count extremes around the threshold
    tab_r = '{32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 32'hFFFF_FFFE};
    tab_s = '{32'h0, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0};
    dec_lat = 2;
    run_scan(4'b1111, 32'hFFFF_FFFE, -1, 0);

    // randomized scans
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 4; i++) begin
        tab_r[i] = (k == 4) ? $urandom : 32'(1000 + $urandom_range(0, 40));
        tab_s[i] = (k == 4) ? $urandom : 32'(1000 + $urandom_range(0, 40));
      end
      dec_lat = $urandom_range(0, 5);
      run_scan(4'($urandom_range(1, 15)), (k == 4) ? $urandom : 32'($urandom_range(0, 20)),
               $urandom_range(0, 3), $urandom_range(0, 4));
    end

    // reset while measuring channel 2
    res_ready = 1'b1; dec_lat = 2;
    en_out = 1'b1; chan_mask = 4'hF; thr = 32'd5;
    @(negedge clk);
    en_out = 1'b0;
    n = 0;
    while (!(mode === 2'b10 && r_mux_sel === 2'd2) && n < 300) begin @(negedge clk); n++; end
    check("reach_chan2", 64'(n < 300), 64'd1);
    rst = 1'b1; @(negedge clk);
    rst = 1'b0; res_ready = 1'b0;
    exp_map = '0;
    check_reset("mid_reset");
    seen = 1'b0;
    repeat (10) begin @(negedge clk); if (done === 1'b1 || busy !== 1'b0) seen = 1'b1; end
    check("mid_reset_quiet", 64'(seen), 64'd0);

    // empty mask: straight to done, no results
    en_out = 1'b1; chan_mask = 4'b0000;
    @(negedge clk);
    en_out = 1'b0;
    n = 1; seen = 1'b0;
    while (done !== 1'b1 && n < 20) begin
      if (res_valid === 1'b1) seen = 1'b1;
      @(negedge clk); n++;
    end
    check("empty_done_lat", 64'(n), 64'd2);
    check("empty_no_res", 64'(seen | res_valid), 64'd0);
    @(negedge clk);
    check("empty_done_pulse", 64'({done, busy, aged_map}), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
